wide_add_seq: RTL and testbench
===============================

# wide_add_seq

Multi-cycle sequencer that performs NBYTES×8-bit addition or subtraction by streaming operand bytes, least-significant first, through a single 8-bit `conditional_sum_adder`, one byte per clock. The carry is chained through a register between bytes. The block sits between a requester that issues `start` with full-width operands and the shared 8-bit adder datapath, trading latency for area. A start/busy/done handshake frames each operation.

## Interface
- `NBYTES`, default 4: number of 8-bit slices per operand; legal range ≥ 2.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request a new operation; accepted only in IDLE.
- `sub` input 1: 0 = a+b+cin; 1 = a−b (b inverted, initial carry forced to 1, `cin` ignored).
- `a` input 8·NBYTES: operand A, sampled on the accepting edge.
- `b` input 8·NBYTES: operand B, sampled on the accepting edge.
- `cin` input 1: carry-in for add; sampled on the accepting edge.
- `busy` output 1: high in RUN and DONE.
- `done` output 1: one-cycle pulse; result valid.
- `s` output 8·NBYTES: result word.
- `cout` output 1: final carry-out; for sub, 1 means no borrow.
- `ovf` output 1: signed two's-complement overflow of the final result.

## Operation
- FSM has three states: IDLE, RUN, DONE.
- **IDLE:**
  - When `start` is high at an edge: latch `a`; latch `b` (inverted when `sub`=1); set the carry reg to `cin` (or to 1 when `sub`=1); clear `s`; clear byte index `idx`; go to RUN.
  - When `start` is low, remain in IDLE.
- **RUN**, each edge:
  - Adder inputs are byte `idx` of latched A and B plus the carry reg.
  - `s[8·idx +: 8]` ← adder sum; carry reg ← adder carry-out; `idx` ← `idx`+1.
  - On the edge that processes byte NBYTES−1: `cout` ← adder carry-out; `ovf` ← carry into bit 7 XOR carry out of bit 7 of the top slice; go to DONE.
  - The carry into bit 7 is taken from an adder internal carry tap or recomputed as `s[msb]` ^ `a[msb]` ^ `b'[msb]`.
- **DONE:** `done`=1 for exactly one cycle; then unconditionally return to IDLE.
- `start` is ignored in RUN and DONE; there is no queueing.
- `s`, `cout` and `ovf` hold their values in IDLE until the next accepted `start`, which clears `s` only.
- `idx` width is clog2(NBYTES). `idx` never wraps within an operation because the exit condition is `idx` == NBYTES−1.

## Timing
- Reset (async, immediate) drives: state=IDLE, `busy`=0, `done`=0, `s`=0, `cout`=0, `ovf`=0, carry reg=0, `idx`=0.
- Reset during RUN or DONE aborts the operation. No `done` is produced, and the partial result is discarded.
- Let E0 be the edge that samples `start`:
  - Bytes 0..NBYTES−1 are processed on edges E1..E_NBYTES.
  - `done` is high from E_NBYTES to E_NBYTES+1.
  - Latency from the `start` edge to `done` is NBYTES cycles. Throughput is one operation per NBYTES+2 cycles (the next `start` is accepted at E_NBYTES+2).
- `busy` is a Moore output; it rises after E0 and falls after E_NBYTES+1.
- The adder path is combinational within one cycle; there is no internal pipelining.
- Operand inputs may change freely after E0 without affecting the result.

## Structure
- Shared package holds:
  - `BYTE_W` = 8;
  - state enum {IDLE, RUN, DONE};
  - a function computing `idx` width from NBYTES.
- One sub-module instance: `conditional_sum_adder` (existing 8-bit x, y, cin → s, cout), used as the sequenced datapath.
- Byte selection uses indexed part-selects (`+:`). No per-byte adder copies.

## Test plan
- NBYTES=4, add: a=0xFFFFFFFF, b=0x00000001, cin=0 → s=0x00000000, cout=1, ovf=0; `done` pulses exactly 4 cycles after the `start` edge.
- Add with `cin`: a=0x12345678, b=0x11111111, cin=1 → s=0x2345678A, cout=0, ovf=0.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, cin=0 → s=0x80000000, ovf=1, cout=0.
- Sub: a=0x00000005, b=0x00000007, sub=1, cin=1 (ignored) → s=0xFFFFFFFE, cout=0, ovf=0.
- Second `start` with different operands, asserted 2 cycles into RUN → ignored; first result unchanged; a new `start` in the cycle after `done` is accepted.
- `rst` pulsed at the 2nd RUN cycle → all outputs 0 immediately, no `done`; the next operation (0x00000001+0x00000001) yields s=0x00000002 normally.

Source files
------------

// File: rtl/wide_add_seq_pkg.sv
// Shared definitions for the byte-serial wide adder: slice width, FSM states
// and the byte-index width helper.
package wide_add_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the byte index; at least one bit even for degenerate sizes.
    function automatic int idx_width(input int nbytes);
        return (nbytes < 2) ? 1 : $clog2(nbytes);
    endfunction

endpackage

// File: rtl/wide_add_seq_if.sv
// Request/result bundle between a requester (master) and the sequencer (slave).
interface wide_add_seq_if #(
    parameter int NBYTES = 4
);
    import wide_add_seq_pkg::*;

    logic                       start;
    logic                       sub;
    logic [BYTE_W*NBYTES-1:0]   a;
    logic [BYTE_W*NBYTES-1:0]   b;
    logic                       cin;
    logic                       busy;
    logic                       done;
    logic [BYTE_W*NBYTES-1:0]   s;
    logic                       cout;
    logic                       ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, s, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, s, cout, ovf
    );

endinterface

// File: rtl/wide_add_seq_adder.sv
// 8-bit conditional-sum adder: the low half ripples, the high half is
// evaluated for both possible carries and selected by the low-half carry.
module conditional_sum_adder
    import wide_add_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] x,
    input  logic [BYTE_W-1:0] y,
    input  logic              cin,
    output logic [BYTE_W-1:0] s,
    output logic              cout
);
    localparam int HALF = BYTE_W / 2;

    logic [HALF:0]   c_lo;
    logic [HALF:0]   c_hi0;
    logic [HALF:0]   c_hi1;
    logic [HALF-1:0] s_hi0;
    logic [HALF-1:0] s_hi1;

    assign c_lo[0]  = cin;
    assign c_hi0[0] = 1'b0;
    assign c_hi1[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < HALF; gi++) begin : g_bit
            // Low half: plain ripple from the real carry-in.
            assign s[gi]        = x[gi] ^ y[gi] ^ c_lo[gi];
            assign c_lo[gi+1]   = (x[gi] & y[gi]) | (c_lo[gi] & (x[gi] ^ y[gi]));
            // High half: speculative copies for carry 0 and carry 1.
            assign s_hi0[gi]    = x[gi+HALF] ^ y[gi+HALF] ^ c_hi0[gi];
            assign c_hi0[gi+1]  = (x[gi+HALF] & y[gi+HALF]) |
                                  (c_hi0[gi] & (x[gi+HALF] ^ y[gi+HALF]));
            assign s_hi1[gi]    = x[gi+HALF] ^ y[gi+HALF] ^ c_hi1[gi];
            assign c_hi1[gi+1]  = (x[gi+HALF] & y[gi+HALF]) |
                                  (c_hi1[gi] & (x[gi+HALF] ^ y[gi+HALF]));
        end
    endgenerate

    assign s[BYTE_W-1:HALF] = c_lo[HALF] ? s_hi1 : s_hi0;
    assign cout             = c_lo[HALF] ? c_hi1[HALF] : c_hi0[HALF];

endmodule

// File: rtl/wide_add_seq.sv
// Byte-serial NBYTES*8-bit add/subtract sequencer. Operands are latched on
// start and streamed LSB-first through one shared 8-bit adder, chaining the
// carry through a register. done pulses for one cycle when the result is valid.
module wide_add_seq
    import wide_add_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic          clk,
    input  logic          rst,
    wide_add_seq_if.slave bus
);
    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = idx_width(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t             state_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       s_q;
    logic               carry_q;
    logic               cout_q;
    logic               ovf_q;
    logic               busy_q;
    logic               done_q;
    logic [IDX_W-1:0]   idx_q;

    logic [BYTE_W-1:0]  a_byte;
    logic [BYTE_W-1:0]  b_byte;
    logic [BYTE_W-1:0]  sum_byte;
    logic               add_cout;
    logic               c7;
    logic               ovf_d;
    logic [W-1:0]       s_d;

    // Select the current slice of the latched operands.
    assign a_byte = a_q[int'(idx_q) * BYTE_W +: BYTE_W];
    assign b_byte = b_q[int'(idx_q) * BYTE_W +: BYTE_W];

    conditional_sum_adder u_adder (
        .x    (a_byte),
        .y    (b_byte),
        .cin  (carry_q),
        .s    (sum_byte),
        .cout (add_cout)
    );

    // Carry into the slice MSB, recovered from the sum bit and its operands.
    assign c7    = sum_byte[BYTE_W-1] ^ a_byte[BYTE_W-1] ^ b_byte[BYTE_W-1];
    assign ovf_d = c7 ^ add_cout;

    // Merge the freshly computed slice into the result word.
    always_comb begin
        s_d = s_q;
        s_d[int'(idx_q) * BYTE_W +: BYTE_W] = sum_byte;
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        // Subtraction is a + ~b + 1; cin is irrelevant then.
                        b_q     <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.sub ? 1'b1 : bus.cin;
                        s_q     <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    s_q     <= s_d;
                    carry_q <= add_cout;
                    if (idx_q == LAST_IDX) begin
                        cout_q  <= add_cout;
                        ovf_q   <= ovf_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.s    = s_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq (NBYTES=4) using a result scoreboard.
module tb_wide_add_seq;
    import wide_add_seq_pkg::*;

    localparam int NB = 4;
    localparam int W  = BYTE_W * NB;

    typedef struct packed {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t sb_q[$];

    wide_add_seq_if #(.NBYTES(NB)) bus ();

    wide_add_seq #(.NBYTES(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full-width arithmetic, overflow from operand/result signs.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t         e;
        logic [W-1:0] bb;
        logic         c;
        logic [W:0]   r;
        bb     = sub ? ~b : b;
        c      = sub ? 1'b1 : cin;
        r      = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
        e.s    = r[W-1:0];
        e.cout = r[W];
        e.ovf  = (a[W-1] == bb[W-1]) && (e.s[W-1] != a[W-1]);
        return e;
    endfunction

    // Present one start pulse sampled at the next rising edge, then scramble operands.
    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic sub, input exp_t e);
        sb_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        bus.sub   = sub;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.cin   = 1'($urandom);
        bus.sub   = 1'($urandom);
    endtask

    // Count rising edges until done is seen (-1 if the bound expires).
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic run_and_check(input string name, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic cin,
                                 input logic sub, input exp_t e);
        int   cyc;
        exp_t got;
        drive_start(a, b, cin, sub, e);
        wait_done(cyc);
        checks++;
        if (cyc !== NB) begin
            failures++;
            $display("FAIL %s latency: got %0d cycles expected %0d", name, cyc, NB);
        end
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_at_done: got %b expected 1", name, bus.busy);
        end
        got = sb_q.pop_front();
        checks++;
        if (bus.s !== got.s || bus.cout !== got.cout || bus.ovf !== got.ovf) begin
            failures++;
            $display("FAIL %s result: got s=%h cout=%b ovf=%b expected s=%h cout=%b ovf=%b",
                     name, bus.s, bus.cout, bus.ovf, got.s, got.cout, got.ovf);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.s !== got.s) begin
            failures++;
            $display("FAIL %s after_done: got done=%b busy=%b s=%h expected done=0 busy=0 s=%h",
                     name, bus.done, bus.busy, bus.s, got.s);
        end
        $display("op %s a=%h b=%h cin=%b sub=%b -> s=%h cout=%b ovf=%b",
                 name, a, b, cin, sub, bus.s, bus.cout, bus.ovf);
    endtask

    task automatic test_reset;
        @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.s !== '0 ||
            bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got busy=%b done=%b s=%h cout=%b ovf=%b expected all 0",
                     bus.busy, bus.done, bus.s, bus.cout, bus.ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_start: got busy=%b expected 0", bus.busy);
        end
        $display("reset checked");
    endtask

    task automatic test_vectors;
        run_and_check("carry_wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0,
                      '{s: 32'h00000000, cout: 1'b1, ovf: 1'b0});
        run_and_check("add_cin", 32'h12345678, 32'h11111111, 1'b1, 1'b0,
                      '{s: 32'h2345678A, cout: 1'b0, ovf: 1'b0});
        run_and_check("signed_ovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0,
                      '{s: 32'h80000000, cout: 1'b0, ovf: 1'b1});
        run_and_check("sub_borrow", 32'h00000005, 32'h00000007, 1'b1, 1'b1,
                      '{s: 32'hFFFFFFFE, cout: 1'b0, ovf: 1'b0});
        run_and_check("sub_ovf", 32'h80000000, 32'h00000001, 1'b0, 1'b1,
                      '{s: 32'h7FFFFFFF, cout: 1'b1, ovf: 1'b1});
    endtask

    task automatic test_random;
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic         cin;
            logic         sub;
            a   = $urandom;
            b   = $urandom;
            cin = 1'($urandom);
            sub = 1'($urandom);
            run_and_check("random", a, b, cin, sub, model(a, b, cin, sub));
        end
    endtask

    task automatic test_back_to_back;
        int   cyc;
        exp_t got;
        drive_start(32'h01020304, 32'h10203040, 1'b0, 1'b0,
                    model(32'h01020304, 32'h10203040, 1'b0, 1'b0));
        @(posedge clk);
        @(posedge clk);
        #1;
        // Intruding start two cycles into RUN must be ignored.
        bus.start = 1'b1;
        bus.a     = 32'hAAAAAAAA;
        bus.b     = 32'h55555555;
        bus.sub   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(cyc);
        checks++;
        if (cyc !== 1) begin
            failures++;
            $display("FAIL ignore_start_latency: got %0d expected 1", cyc);
        end
        got = sb_q.pop_front();
        checks++;
        if (bus.s !== got.s || bus.cout !== got.cout || bus.ovf !== got.ovf) begin
            failures++;
            $display("FAIL ignore_start_result: got s=%h cout=%b ovf=%b expected s=%h cout=%b ovf=%b",
                     bus.s, bus.cout, bus.ovf, got.s, got.cout, got.ovf);
        end
        $display("op ignore_start -> s=%h", bus.s);
        // Start during the cycle after done (sampled at E_NBYTES+2).
        @(posedge clk);
        #1;
        sb_q.push_back(model(32'h0000FFFF, 32'h00000001, 1'b1, 1'b0));
        bus.start = 1'b1;
        bus.a     = 32'h0000FFFF;
        bus.b     = 32'h00000001;
        bus.cin   = 1'b1;
        bus.sub   = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL next_start_accept: got busy=%b expected 1", bus.busy);
        end
        wait_done(cyc);
        checks++;
        if (cyc !== NB) begin
            failures++;
            $display("FAIL next_start_latency: got %0d expected %0d", cyc, NB);
        end
        got = sb_q.pop_front();
        checks++;
        if (bus.s !== got.s || bus.cout !== got.cout || bus.ovf !== got.ovf) begin
            failures++;
            $display("FAIL next_start_result: got s=%h cout=%b ovf=%b expected s=%h cout=%b ovf=%b",
                     bus.s, bus.cout, bus.ovf, got.s, got.cout, got.ovf);
        end
        $display("op back_to_back -> s=%h", bus.s);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_run;
        logic saw_done;
        exp_t dropped;
        drive_start(32'hDEADBEEF, 32'h01010101, 1'b0, 1'b0,
                    model(32'hDEADBEEF, 32'h01010101, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.s !== '0 ||
            bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
            failures++;
            $display("FAIL midrun_reset: got busy=%b done=%b s=%h cout=%b ovf=%b expected all 0",
                     bus.busy, bus.done, bus.s, bus.cout, bus.ovf);
        end
        dropped = sb_q.pop_back();
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            failures++;
            $display("FAIL midrun_no_done: got done seen=%b expected 0", saw_done);
        end
        $display("op reset_abort discarded s=%h", dropped.s);
        run_and_check("after_reset", 32'h00000001, 32'h00000001, 1'b0, 1'b0,
                      '{s: 32'h00000002, cout: 1'b0, ovf: 1'b0});
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        test_reset();
        test_vectors();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        checks++;
        if (sb_q.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_empty: got %0d entries expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
